// File: rtl/sc_io_pkg.sv
// Shared definitions for the single-cycle computer I/O responder.
// Register offsets, the blank segment pattern and the active-low seven-segment decode.
package sc_io_pkg;

  localparam logic [4:0] IO_SW       = 5'h00;
  localparam logic [4:0] IO_KEYLVL   = 5'h04;
  localparam logic [4:0] IO_KEYEDGE  = 5'h08;
  localparam logic [4:0] IO_HEXVAL   = 5'h0C;
  localparam logic [4:0] IO_HEXBLANK = 5'h10;
  localparam logic [4:0] IO_LED      = 5'h14;
  localparam logic [4:0] IO_CYCLES   = 5'h18;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sc_io_debounce.sv
// Per-key synchronizer and debouncer; level follows the key 2 + DEB_CYCLES edges after a clean change.
// rise is combinational and high in the cycle before the edge on which level goes 0 -> 1.
module sc_io_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          expire;

  // Any mismatch-free cycle restarts the count, so glitches never accumulate.
  assign expire = (s2 != stable) && (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (expire) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = expire & s2;

endmodule

// File: rtl/sc_io_port.sv
// Memory-mapped I/O window for switches, keys, LEDs and six seven-segment digits.
// Stores commit on the rising edge and show up the next cycle; reads are combinational; no backpressure.
module sc_io_port
  import sc_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h0000_00C0,
  parameter int          DEB_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        sel,
  input  logic [9:0]  sw,
  input  logic [3:1]  key,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [9:0]  led
);

  logic [4:0]  off;
  logic        wr;
  logic [9:0]  sw_s1;
  logic [9:0]  sw_s2;
  logic [2:0]  lvl;
  logic [2:0]  rise;
  logic [2:0]  keyedge;
  logic [2:0]  edge_clr;
  logic [23:0] hexval;
  logic [5:0]  hexblank;
  logic [9:0]  led_r;
  logic [31:0] cycles;
  logic [6:0]  seg [6];
  logic        unused_bits;

  assign sel         = (addr[31:5] == IO_BASE[31:5]);
  assign off         = {addr[4:2], 2'b00};
  assign wr          = sel & we;
  assign unused_bits = ^{addr[1:0], datain[31:24]};

  for (genvar k = 0; k < 3; k++) begin : g_key
    sc_io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (key[k+1]),
      .level  (lvl[k]),
      .rise   (rise[k])
    );
  end

  always_comb begin
    edge_clr = 3'b000;
    if (wr && (off == IO_KEYEDGE)) begin
      edge_clr = datain[2:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      keyedge  <= '0;
      hexval   <= '0;
      hexblank <= 6'h3F;
      led_r    <= '0;
      cycles   <= '0;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      cycles  <= cycles + 32'd1;
      // A press edge arriving with a clear of the same bit must not be lost.
      keyedge <= (keyedge & ~edge_clr) | rise;
      if (wr) begin
        case (off)
          IO_HEXVAL:   hexval   <= datain[23:0];
          IO_HEXBLANK: hexblank <= datain[5:0];
          IO_LED:      led_r    <= datain[9:0];
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    dataout = 32'h0;
    if (sel) begin
      case (off)
        IO_SW:       dataout = {22'b0, sw_s2};
        IO_KEYLVL:   dataout = {29'b0, lvl};
        IO_KEYEDGE:  dataout = {29'b0, keyedge};
        IO_HEXVAL:   dataout = {8'b0, hexval};
        IO_HEXBLANK: dataout = {26'b0, hexblank};
        IO_LED:      dataout = {22'b0, led_r};
        IO_CYCLES:   dataout = cycles;
        default:     dataout = 32'h0;
      endcase
    end
  end

  for (genvar n = 0; n < 6; n++) begin : g_hex
    assign seg[n] = hexblank[n] ? SEG_BLANK : seg7(hexval[4*n +: 4]);
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];
  assign led  = led_r;

endmodule

// File: tb/tb_sc_io_port.sv
// Bench for sc_io_port with DEB_CYCLES = 4: directed stimulus, a window-based behavioural model
// compared on every falling edge, and hand-computed literal expectations from the test plan.
module tb_sc_io_port;

  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h0000_00C0;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic        sel;
  logic [9:0]  sw;
  logic [3:1]  key;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic [9:0]  led;
  logic [6:0]  hx [6];

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  sc_io_port #(.IO_BASE(BASE), .DEB_CYCLES(DEB)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .dataout (dataout),
    .sel     (sel),
    .sw      (sw),
    .key     (key),
    .hex5    (hex5),
    .hex4    (hex4),
    .hex3    (hex3),
    .hex2    (hex2),
    .hex1    (hex1),
    .hex0    (hex0),
    .led     (led)
  );

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state: register contents plus a history of input samples, newest first.
  logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [9:0]  swq [$];
  logic [2:0]  kq [$];
  logic [2:0]  m_lvl, m_edge, m_set, m_clr;
  logic [23:0] m_hex;
  logic [5:0]  m_blank;
  logic [9:0]  m_led;
  logic [31:0] m_cyc;

  function automatic logic m_sel(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_sel(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return {22'b0, swq[1]};
      3'd1:    return {29'b0, m_lvl};
      3'd2:    return {29'b0, m_edge};
      3'd3:    return {8'b0, m_hex};
      3'd4:    return {26'b0, m_blank};
      3'd5:    return {22'b0, m_led};
      3'd6:    return m_cyc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [6:0] m_seg(input int n);
    return m_blank[n] ? 7'h7F : seg_tbl[m_hex[4*n +: 4]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // A key's level takes value v once the last DEB synchronized samples
  // (raw samples 2..DEB+1 edges old) all equal v and differ from the level.
  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      swq.delete();
      kq.delete();
      for (int i = 0; i < DEB + 2; i++) begin
        swq.push_front(10'h0);
        kq.push_front(3'b000);
      end
      m_lvl = 0; m_edge = 0; m_hex = 0; m_blank = 6'h3F; m_led = 0; m_cyc = 0;
    end else begin
      swq.push_front(sw);
      kq.push_front(~key);
      void'(swq.pop_back());
      void'(kq.pop_back());
      m_set = 3'b000;
      m_clr = 3'b000;
      for (int i = 0; i < 3; i++) begin
        logic all_same;
        all_same = 1'b1;
        for (int j = 3; j <= DEB + 1; j++)
          if (kq[j][i] != kq[2][i]) all_same = 1'b0;
        if (all_same && (kq[2][i] != m_lvl[i])) begin
          m_lvl[i] = kq[2][i];
          if (kq[2][i]) m_set[i] = 1'b1;
        end
      end
      if (m_sel(addr) && we) begin
        case (addr[4:2])
          3'd2: m_clr = datain[2:0];
          3'd3: m_hex = datain[23:0];
          3'd4: m_blank = datain[5:0];
          3'd5: m_led = datain[9:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~m_clr) | m_set;
      m_cyc  = m_cyc + 32'd1;
    end
  end

  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      chk("sel", {31'b0, sel}, {31'b0, m_sel(addr)});
      chk("dataout", dataout, m_read(addr));
      chk("led", {22'b0, led}, {22'b0, m_led});
      for (int n = 0; n < 6; n++)
        chk($sformatf("hex%0d", n), {25'b0, hx[n]}, {25'b0, m_seg(n)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic nsync();
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; datain = d; we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dataout, exp);
  endtask

  initial begin
    resetn = 1'b0; key = 3'b111; sw = 10'h0; addr = 32'hD8; datain = 32'h0; we = 1'b0;
    @(posedge clock);
    cmp_en = 1'b1;
    nsync();
    rd("rst_cycles", 32'hD8, 32'h0);
    chk("rst_hex0", {25'b0, hex0}, 32'h7F);
    chk("rst_hex5", {25'b0, hex5}, 32'h7F);
    chk("rst_led", {22'b0, led}, 32'h0);
    step(1);
    resetn = 1'b1;
    rd("rst_blank", 32'hD0, 32'h3F);
    step(4);
    rd("cycles_4", 32'hD8, 32'd4);

    // Display path
    wr(32'hCC, 32'h00A5F3);
    wr(32'hD0, 32'h0);
    nsync();
    chk("disp_hex0", {25'b0, hex0}, 32'h30);
    chk("disp_hex1", {25'b0, hex1}, 32'h0E);
    chk("disp_hex2", {25'b0, hex2}, 32'h12);
    chk("disp_hex3", {25'b0, hex3}, 32'h08);
    chk("disp_hex4", {25'b0, hex4}, 32'h40);
    chk("disp_hex5", {25'b0, hex5}, 32'h40);
    wr(32'hD4, 32'h3FF);
    nsync();
    chk("led_all", {22'b0, led}, 32'h3FF);

    // Clean press of key[1]: level exactly 6 edges after the fall
    key = 3'b110;
    addr = 32'hC4;
    step(5);
    rd("press_lvl_e5", 32'hC4, 32'h0);
    step(1);
    rd("press_lvl_e6", 32'hC4, 32'h1);
    rd("press_edge", 32'hC8, 32'h1);
    step(4);
    key = 3'b111;
    step(8);
    rd("release_lvl", 32'hC4, 32'h0);
    rd("release_edge", 32'hC8, 32'h1);
    wr(32'hC8, 32'h1);
    rd("w1c_edge", 32'hC8, 32'h0);

    // Bounce on key[2]: low runs of 3 never qualify
    for (int r = 0; r < 5; r++) begin
      key = 3'b101;
      step(3);
      key = 3'b111;
      step(1);
    end
    step(10);
    rd("bounce_lvl", 32'hC4, 32'h0);
    rd("bounce_edge", 32'hC8, 32'h0);

    // Clear of bit1 on the edge where key[2] becomes pressed
    key = 3'b101;
    step(5);
    addr = 32'hC8; datain = 32'h2; we = 1'b1;
    step(1);
    we = 1'b0;
    rd("collide_edge", 32'hC8, 32'h2);
    rd("collide_lvl", 32'hC4, 32'h2);
    key = 3'b111;
    step(8);

    // Switches and window decode
    sw = 10'h2A5;
    addr = 32'hC0;
    step(1);
    rd("sw_e1", 32'hC0, 32'h0);
    step(1);
    rd("sw_e2", 32'hC0, 32'h2A5);
    rd("reserved", 32'hDC, 32'h0);
    addr = 32'hE0; datain = 32'hFFFF_FFFF; we = 1'b1;
    #1;
    chk("out_sel", {31'b0, sel}, 32'h0);
    chk("out_data", dataout, 32'h0);
    step(1);
    we = 1'b0;
    rd("out_led", 32'hD4, 32'h3FF);
    rd("out_hexval", 32'hCC, 32'h00A5F3);
    rd("out_blank", 32'hD0, 32'h0);

    // Reset in the middle of a key[3] debounce
    key = 3'b011;
    step(3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_hex0", {25'b0, hex0}, 32'h7F);
    chk("mid_rst_led", {22'b0, led}, 32'h0);
    rd("mid_rst_lvl", 32'hC4, 32'h0);
    step(2);
    resetn = 1'b1;
    step(5);
    rd("post_rst_lvl_e5", 32'hC4, 32'h0);
    step(1);
    rd("post_rst_lvl_e6", 32'hC4, 32'h4);
    key = 3'b111;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_io_port.md
# sc_io_port

Memory-mapped I/O responder for the single-cycle computer's data bus. It answers CPU load/store accesses that fall in a fixed I/O window and connects the board's switches, keys, LEDs and six seven-segment displays. Switches are synchronized; keys are synchronized, debounced and edge-captured. The responder sits beside the data memory and shares the CPU's address, write-data and write-enable lines; the data-memory block selects `dataout` when an address hits the window.

## Interface
Parameters:
- `IO_BASE`, default 32'h0000_00C0: window base address, 32-byte aligned; decodes `addr[31:5]`.
- `DEB_CYCLES`, default 500000: number of stable clock cycles required to accept a key change. Must be ≥ 2.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `addr`  in  32: CPU byte address; word offset is `addr[4:2]`.
- `datain`  in  32: CPU store data.
- `we`  in  1: CPU store strobe.
- `dataout`  out  32: read data, combinational from `addr` and register state.
- `sel`  out  1: high when `addr[31:5] == IO_BASE[31:5]`.
- `sw`  in  10: raw slide switches, asynchronous.
- `key`  in  3 (`[3:1]`): raw push buttons, active-low, asynchronous.
- `hex5`…`hex0`  out  7 each: segment drives, active-low, `{g,f,e,d,c,b,a}`.
- `led`  out  10: LED register.

## Operation
Register map (offset: access, meaning):
- 0x00 SW: read-only. `{22'b0, sw_sync}`.
- 0x04 KEYLVL: read-only. `{29'b0, pressed[3:1]}`; a bit is 1 while the debounced key is held down.
- 0x08 KEYEDGE: read / write-1-to-clear. Sticky press-edge flags in bits [2:0].
- 0x0C HEXVAL: read/write, bits [23:0]. Nibble n drives `hexn`.
- 0x10 HEXBLANK: read/write, bits [5:0]. A set bit n blanks `hexn`, forcing it to 7'h7F.
- 0x14 LED: read/write, bits [9:0]; drives `led` directly.
- 0x18 CYCLES: read-only. 32-bit free-running counter, increments every clock, wraps from 0xFFFF_FFFF to 0.
- 0x1C: reserved. Reads 0; writes are ignored.

Read and write rules:
- Unused register bits read 0.
- When `sel` is 0, `dataout` is 0 and writes are ignored.
- A store commits when `sel & we` on the rising edge.

Switch synchronizer:
- Two-flop synchronizer per bit, reset value 0.

Key path, per key:
- Two-flop synchronizer on `~key`, reset value 0.
- Debounce counter: if the synchronized value equals the stable value, counter ← 0. Otherwise counter increments; when it reaches `DEB_CYCLES-1`, the stable value takes the synchronized value and the counter ← 0.
- A 0→1 change of the stable value sets the KEYEDGE bit.
- A KEYEDGE write with bit=1 clears that bit.
- If a set and a clear occur in the same cycle, the set wins.

Seven-segment decode (active-low):
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E (hex values).

Reset values:
- Synchronizers, debounce counters, stable values, KEYEDGE, HEXVAL, LED, CYCLES: all 0.
- HEXBLANK: 6'h3F, so every `hexn` drives 7'h7F.
- `led`: 0.

## Timing
- Store to output: a register write is visible on `led`/`hexn` and in `dataout` in the cycle after the commit edge.
- Switch latency: a `sw` change appears in SW after 2 edges.
- Key latency: a clean `key` press reaches KEYLVL and KEYEDGE after 2 + `DEB_CYCLES` edges.
- Glitches: a glitch shorter than `DEB_CYCLES` synchronized cycles never changes the stable value, because the counter restarts on every mismatch.
- CYCLES: reads N on the Nth edge after reset is released.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending debounce is discarded.

## Structure
- Shared package `sc_io_pkg`:
  - offset constants `IO_SW`, `IO_KEYLVL`, `IO_KEYEDGE`, `IO_HEXVAL`, `IO_HEXBLANK`, `IO_LED`, `IO_CYCLES`;
  - `SEG_BLANK = 7'h7F`;
  - the seven-segment decode function.
- Sub-module `sc_io_debounce`:
  - one instance per key;
  - contains the synchronizer, counter and stable value;
  - outputs `level` and a one-cycle `rise` pulse;
  - parameter `DEB_CYCLES`.
- Top level holds address decode, register file, read mux and CYCLES counter.

## Test plan
All scenarios use `DEB_CYCLES` = 4 and `IO_BASE` = 0xC0.
- Reset check: after reset, `hex0`..`hex5` = 7'h7F, `led` = 0, read 0xD0 → 0x3F, read 0xD8 → 0.
- Display path: write 0xCC ← 0x00A5F3, then 0xD0 ← 0.
  - Next cycle: `hex0` = 0x30, `hex1` = 0x0E, `hex2` = 0x12, `hex3` = 0x08, `hex4` = `hex5` = 0x40.
  - Write 0xD4 ← 0x3FF → `led` = 10'h3FF.
- Key press: hold `key[1]` low 10 cycles.
  - KEYLVL bit0 = 1 exactly 6 edges after the fall; KEYEDGE = 0x1.
  - Release: KEYLVL → 0 while KEYEDGE stays 0x1.
  - Write 0xC8 ← 0x1 → KEYEDGE = 0.
- Bounce: pulse `key[2]` low for 3 cycles, high 1 cycle, repeated 5 times, then high → KEYLVL and KEYEDGE stay 0.
- Set/clear collision: W1C of bit1 on the same edge that `key[2]`'s stable value rises → KEYEDGE bit1 = 1.
- Window and switches:
  - `sw` = 0x2A5 → read 0xC0 = 0x2A5 after 2 edges.
  - Read 0xDC → 0.
  - Write 0xE0 (outside window) → `sel` = 0, `dataout` = 0, no register changes.
